n2m_rr_arbiter: RTL

Round-robin arbiter that shares one downstream resource among N requesters. It produces a registered one-hot grant vector and its M-bit binary index, which drives the index-encoded select of the shared datapath. Each grant is held until the owner releases it. An optional watchdog forcibly reclaims a grant that is held too long.

---
 rtl/n2m_rr_arbiter_if.sv | 23 ++
 rtl/n2m_rr_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/n2m_rr_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface n2m_rr_arbiter_if #(
  parameter int N = 42,
  parameter int M = 6
);
  logic [N-1:0] Req_i;
  logic         Rel_i;
  logic         Gnt_Vld_o;
  logic [N-1:0] Gnt_OneHot_o;
  logic [M-1:0] Gnt_Idx_o;
  logic         Tmo_o;

  modport master (
    output Req_i, Rel_i,
    input  Gnt_Vld_o, Gnt_OneHot_o, Gnt_Idx_o, Tmo_o
  );

  modport slave (
    input  Req_i, Rel_i,
    output Gnt_Vld_o, Gnt_OneHot_o, Gnt_Idx_o, Tmo_o
  );
endinterface

// File: rtl/n2m_rr_arbiter.sv
// Round-robin N-requester arbiter with held one-hot/index grant.
// Define N2M_ARB_TIMEOUT_EN to add the HOLD_MAX watchdog that forces a release.
module n2m_rr_arbiter #(
  parameter int N        = 42,
  parameter int M        = 6,
  parameter int HOLD_MAX = 255
) (
  input  logic           Clk_i,
  input  logic           Rst_i,
  n2m_rr_arbiter_if.slave arb
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t       state_q;
  logic [M-1:0] ptr_q, ptr_d;
  logic         vld_q;
  logic [N-1:0] oh_q, oh_d;
  logic [M-1:0] idx_q;
  logic [M-1:0] win_idx;
  logic         win_found;
  logic [M:0]   cand;
  logic         tmo_hit;

  // Search starts at ptr_q and wraps at N (not 2**M), so cand never exceeds 2N-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (M+1)'(i);
      if (cand >= (M+1)'(N)) cand = cand - (M+1)'(N);
      if (!win_found && arb.Req_i[cand[M-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[M-1:0];
      end
    end
  end

  assign ptr_d = (win_idx == M'(N-1)) ? '0 : win_idx + 1'b1;
  assign oh_d  = {{(N-1){1'b0}}, 1'b1} << win_idx;

`ifdef N2M_ARB_TIMEOUT_EN
  logic [7:0] hold_q;
  logic       tmo_q;
  assign tmo_hit   = (hold_q == 8'(HOLD_MAX - 1));
  assign arb.Tmo_o = tmo_q;
`else
  logic unused_hold_max;
  assign unused_hold_max = ^8'(HOLD_MAX);
  assign tmo_hit         = 1'b0;
  assign arb.Tmo_o       = 1'b0;
`endif

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      vld_q   <= 1'b0;
      oh_q    <= '0;
      idx_q   <= '0;
`ifdef N2M_ARB_TIMEOUT_EN
      hold_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
`ifdef N2M_ARB_TIMEOUT_EN
      tmo_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q <= GRANT;
            vld_q   <= 1'b1;
            oh_q    <= oh_d;
            idx_q   <= win_idx;
            ptr_q   <= ptr_d;
`ifdef N2M_ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
          end
        end
        GRANT: begin
          // A simultaneous Rel_i wins over the watchdog: normal release, no Tmo_o.
          if (arb.Rel_i || tmo_hit) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            oh_q    <= '0;
            idx_q   <= '0;
`ifdef N2M_ARB_TIMEOUT_EN
            tmo_q   <= ~arb.Rel_i;
`endif
          end
`ifdef N2M_ARB_TIMEOUT_EN
          else begin
            hold_q <= hold_q + 8'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb.Gnt_Vld_o    = vld_q;
  assign arb.Gnt_OneHot_o = oh_q;
  assign arb.Gnt_Idx_o    = idx_q;

endmodule
